// File: rtl/adc_link_pkg.sv
// adc_link_pkg: constants shared by the ADC serial link transmitter and the
// receiver-side bench. Holds the FSM state encodings, the test-pattern
// select encodings and the default frame geometry / pattern words.
package adc_link_pkg;

    // Frame geometry and fixed pattern words
    localparam int          ADC_BITS      = 12;
    localparam int          ADC_NCH       = 8;
    localparam int          ADC_SYNC_FRMS = 16;
    localparam logic [11:0] ADC_SYNC_WORD = 12'hFC0;
    localparam logic [11:0] ADC_MIDSCALE  = 12'h800;

    // Transmit FSM states (plain constants for legacy tool flows)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // pttn_sel encodings
    localparam logic [1:0] PTTN_NORMAL = 2'b00;
    localparam logic [1:0] PTTN_RAMP   = 2'b01;
    localparam logic [1:0] PTTN_MID    = 2'b10;
    localparam logic [1:0] PTTN_SYNC   = 2'b11;

endpackage

// File: rtl/adc_lane_ser.sv
// adc_lane_ser: one serial lane of the ADC link transmitter. A BITS-wide
// register that loads a whole sample in parallel at a frame boundary and
// then shifts it out MSB first, one bit per clk. The output bit is the
// register MSB, so the lane output is registered.
module adc_lane_ser #(
    parameter int BITS = 12
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            load,
    input  logic            clear,
    input  logic [BITS-1:0] din,
    output logic            sdo
);

    logic [BITS-1:0] sreg;

    // Parallel load at the boundary, forced zero while idle, else shift left
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rstb) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (clear) begin
            sreg <= '0;
        end else begin
            sreg <= {sreg[BITS-2:0], 1'b0};
        end
    end

    assign sdo = sreg[BITS-1];

endmodule

// File: rtl/adc_link_tx.sv
// adc_link_tx: transmit end of the 8-lane, 12-bit serial LVDS ADC link.
// Accepts parallel sample words over valid/ready, sends a SYNC preamble
// after enable, then serializes one word per frame MSB first on every lane
// together with the frame clock fco.
//
// Optional build macro: ADC_TX_TESTPAT_EN compiles in the ramp, midscale
// and sync-word test patterns. Without it pttn_sel is ignored (treated as
// normal data) and the ramp counter does not exist.
module adc_link_tx
    import adc_link_pkg::*;
#(
    parameter int              NCH         = ADC_NCH,
    parameter int              BITS        = ADC_BITS,
    parameter int              SYNC_FRAMES = ADC_SYNC_FRMS,
    parameter logic [BITS-1:0] SYNC_WORD   = ADC_SYNC_WORD,
    parameter logic [BITS-1:0] MIDSCALE    = ADC_MIDSCALE
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                enable,
    input  logic [1:0]          pttn_sel,
    input  logic [NCH*BITS-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                fco,
    output logic [NCH-1:0]      dch,
    output logic                frame_start,
    output logic                tx_run,
    output logic [15:0]         underflow_cnt
);

    localparam int            CW       = $clog2(BITS);
    localparam int            SW       = $clog2(SYNC_FRAMES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
    localparam logic [SW-1:0] LAST_SYN = SW'(SYNC_FRAMES - 1);

    logic [1:0]          state;
    logic [CW-1:0]       bit_cnt;
    logic [SW-1:0]       sync_cnt;
    logic [NCH*BITS-1:0] last_word;
    logic [NCH*BITS-1:0] run_word;
    logic [NCH*BITS-1:0] next_word;
    logic [1:0]          sel_eff;

    logic at_end;     // last bit of a frame is on the wire (SYNC/RUN)
    logic go_sync;    // IDLE exit cycle, also a frame boundary
    logic stop;       // frame ends and enable is low: return to IDLE
    logic sync_last;  // current frame is the final preamble frame
    logic to_run;     // boundary that moves SYNC into RUN
    logic run_load;   // boundary inside RUN that continues transmitting
    logic load;       // any boundary that starts a new frame
    logic clear;      // lanes forced to zero
    logic accept;     // handshake completes this cycle

    // ------------------------------------------------------------------
    // Frame boundary decode
    // ------------------------------------------------------------------
    assign at_end    = (state != ST_IDLE) && (bit_cnt == LAST_BIT);
    assign go_sync   = (state == ST_IDLE) && enable;
    assign stop      = at_end && !enable;
    assign sync_last = (state == ST_SYNC) && (sync_cnt == LAST_SYN);
    assign to_run    = at_end && enable && sync_last;
    assign run_load  = at_end && enable && (state == ST_RUN);
    assign load      = go_sync || (at_end && enable);
    assign clear     = !load && ((state == ST_IDLE) || stop);

    assign tx_run  = (state == ST_RUN);
    assign s_ready = tx_run && enable && (sel_eff == PTTN_NORMAL)
                     && (bit_cnt == LAST_BIT);
    assign accept  = s_valid && s_ready;

    // ------------------------------------------------------------------
    // Pattern selection
    // ------------------------------------------------------------------
`ifdef ADC_TX_TESTPAT_EN
    logic [BITS-1:0] ramp;

    assign sel_eff = pttn_sel;

    // Ramp restarts at 0 on entry to RUN and advances once per RUN frame
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ramp <= '0;
        end else if (to_run || run_load) begin
            ramp <= ramp + 1'b1;
        end else if (state != ST_RUN) begin
            ramp <= '0;
        end
    end
`else
    logic unused_cfg;

    assign sel_eff    = PTTN_NORMAL;
    assign unused_cfg = ^{pttn_sel, MIDSCALE};
`endif

    // Word for the next RUN frame; normal mode repeats the last word when
    // no fresh data is handed over (including the first RUN frame, which
    // is chosen while still in SYNC and so has no handshake slot)
    always_comb begin
        // NOTE: default assignment first so no path leaves run_word
        // unassigned and infers a latch.
        run_word = last_word;
        case (sel_eff)
            PTTN_NORMAL: if (accept) run_word = s_data;
`ifdef ADC_TX_TESTPAT_EN
            PTTN_RAMP:   run_word = {NCH{ramp}};
            PTTN_MID:    run_word = {NCH{MIDSCALE}};
            PTTN_SYNC:   run_word = {NCH{SYNC_WORD}};
`endif
            default:     run_word = last_word;
        endcase
    end

    // Preamble frames carry the sync word; everything after is a RUN word
    assign next_word = (go_sync || ((state == ST_SYNC) && !sync_last))
                       ? {NCH{SYNC_WORD}} : run_word;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------

    // State transitions only at frame boundaries, so frames never truncate
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable) state <= ST_SYNC;
                ST_SYNC: begin
                    if (at_end) begin
                        if (!enable)        state <= ST_IDLE;
                        else if (sync_last) state <= ST_RUN;
                    end
                end
                ST_RUN:  if (stop) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bit counter indexes the bit currently on dch; held at 0 while idle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bit_cnt <= '0;
        end else if ((state == ST_IDLE) || at_end) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Preamble frame counter, restarted on every IDLE exit
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_cnt <= '0;
        end else if (go_sync) begin
            sync_cnt <= '0;
        end else if ((state == ST_SYNC) && at_end && enable && !sync_last) begin
            sync_cnt <= sync_cnt + 1'b1;
        end
    end

    // Frame clock high for the first half of the frame, pulse on the MSB
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fco         <= 1'b0;
            frame_start <= 1'b0;
        end else if (load) begin
            fco         <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            frame_start <= 1'b0;
            if ((state == ST_IDLE) || at_end) begin
                fco <= 1'b0;
            end else begin
                fco <= (int'(bit_cnt) + 1 < BITS / 2);
            end
        end
    end

    // Last accepted word and saturating underflow count
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: last_word is a plain register that must read 0 after reset
        // (it is resent on underflow), so it is reset like any other state.
        if (!rstb) begin
            last_word     <= '0;
            underflow_cnt <= '0;
        end else begin
            if (accept) begin
                last_word <= s_data;
            end
            if (run_load && (sel_eff == PTTN_NORMAL) && !s_valid
                && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane serializers
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        adc_lane_ser #(
            .BITS (BITS)
        ) u_lane (
            .clk   (clk),
            .rstb  (rstb),
            .load  (load),
            .clear (clear),
            .din   (next_word[k*BITS +: BITS]),
            .sdo   (dch[k])
        );
    end

endmodule

// File: tb/tb_adc_link_tx.sv
// tb_adc_link_tx: self-checking bench for adc_link_tx. A frame-level model
// predicts the word on every lane for each frame (preamble, data,
// underflow repeats, test patterns) and every bit cycle is compared.
// Honours ADC_TX_TESTPAT_EN the same way the design does.
module tb_adc_link_tx;

    localparam int          NCH         = 8;
    localparam int          BITS        = 12;
    localparam int          SYNC_FRAMES = 16;
    localparam logic [11:0] SYNC_W      = 12'hFC0;
    localparam logic [11:0] MID_W       = 12'h800;
`ifdef ADC_TX_TESTPAT_EN
    localparam bit TESTPAT     = 1'b1;
    localparam int RAMP_FRAMES = 4100;
`else
    localparam bit TESTPAT     = 1'b0;
    localparam int RAMP_FRAMES = 20;
`endif
    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_RUN  = 2;

    logic                clk = 1'b0;
    logic                rstb;
    logic                enable;
    logic [1:0]          pttn_sel;
    logic [NCH*BITS-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic                fco;
    logic [NCH-1:0]      dch;
    logic                frame_start;
    logic                tx_run;
    logic [15:0]         underflow_cnt;

    adc_link_tx dut (
        .clk           (clk),
        .rstb          (rstb),
        .enable        (enable),
        .pttn_sel      (pttn_sel),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .fco           (fco),
        .dch           (dch),
        .frame_start   (frame_start),
        .tx_run        (tx_run),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (frame level)
    int              mode;
    int              sync_done;
    int              run_idx;
    bit              cur_run;
    logic [11:0]     cur_w  [NCH];
    logic [11:0]     last_w [NCH];
    logic [15:0]     exp_uf;

    // Inputs to present at the next frame boundary
    bit                  nxt_en;
    logic [1:0]          nxt_sel;
    bit                  nxt_valid;
    logic [NCH*BITS-1:0] nxt_data;
    bit                  mid_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_all(input logic [11:0] w);
        for (int k = 0; k < NCH; k++) cur_w[k] = w;
    endtask

    task automatic rand_inputs();
        nxt_en    = 1'b1;
        nxt_sel   = 2'($urandom_range(0, 3));
        nxt_valid = ($urandom_range(0, 9) < 7);
        nxt_data  = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".dch"}, dch, 0);
        check({tag, ".fco"}, fco, 0);
        check({tag, ".frame_start"}, frame_start, 0);
        check({tag, ".tx_run"}, tx_run, 0);
        check({tag, ".s_ready"}, s_ready, 0);
    endtask

    // Word choice for a RUN frame; 'first' is the frame picked while the
    // link is still finishing its preamble (no handshake opportunity)
    task automatic pick_run(input bit first);
        int sel_eff;
        sel_eff = TESTPAT ? int'(nxt_sel) : 0;
        case (sel_eff)
            0: begin
                if (!first) begin
                    if (nxt_valid) begin
                        for (int k = 0; k < NCH; k++) last_w[k] = nxt_data[k*BITS +: BITS];
                    end else if (exp_uf != 16'hFFFF) begin
                        exp_uf++;
                    end
                end
                for (int k = 0; k < NCH; k++) cur_w[k] = last_w[k];
            end
            1:       set_all(12'(run_idx % 4096));
            2:       set_all(MID_W);
            default: set_all(SYNC_W);
        endcase
    endtask

    // Called on the last bit of a frame: present inputs, check s_ready,
    // and advance the model to the following frame
    task automatic plan_next();
        bit was_run;
        int sel_eff;
        was_run  = (mode == M_RUN);
        enable   = nxt_en;
        pttn_sel = nxt_sel;
        s_valid  = nxt_valid;
        s_data   = nxt_data;
        #1;
        sel_eff = TESTPAT ? int'(nxt_sel) : 0;
        check("s_ready@boundary", s_ready, was_run && nxt_en && sel_eff == 0);
        if (!nxt_en) begin
            mode = M_IDLE;
            set_all(12'h000);
        end else if (mode == M_SYNC) begin
            sync_done++;
            if (sync_done == SYNC_FRAMES) begin
                mode    = M_RUN;
                run_idx = 0;
                pick_run(1'b1);
            end else begin
                set_all(SYNC_W);
            end
        end else begin
            run_idx++;
            pick_run(1'b0);
        end
        cur_run = (mode == M_RUN);
    endtask

    // Check nbits cycles of the current frame, starting at its MSB cycle
    task automatic run_frame(input int nbits);
        logic [NCH-1:0] e_dch;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < NCH; k++) e_dch[k] = cur_w[k][BITS-1-b];
            check("dch", dch, e_dch);
            check("fco", fco, b < BITS / 2);
            check("frame_start", frame_start, b == 0);
            check("tx_run", tx_run, cur_run);
            if (b == 0) check("underflow_cnt", underflow_cnt, exp_uf);
            if (b == 5) begin
                pttn_sel = 2'($urandom_range(0, 3));
                s_valid  = 1'($urandom_range(0, 1));
                s_data   = {$urandom(), $urandom(), $urandom()};
                if (mid_drop) enable = 1'b0;
            end
            if (b == BITS - 1) plan_next();
            else check("s_ready@midframe", s_ready, 0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_quiet("idle");
            @(negedge clk);
        end
    endtask

    // Model side of an IDLE exit; caller then advances one cycle
    task automatic start_sync();
        enable    = 1'b1;
        mode      = M_SYNC;
        sync_done = 0;
        cur_run   = 1'b0;
        set_all(SYNC_W);
    endtask

    task automatic preamble(input logic [1:0] entry_sel);
        for (int f = 0; f < SYNC_FRAMES; f++) begin
            rand_inputs();
            if (f == SYNC_FRAMES - 1) nxt_sel = entry_sel;
            run_frame(BITS);
        end
    endtask

    initial begin
        rstb     = 1'b0;
        enable   = 1'b1;
        pttn_sel = 2'b00;
        s_valid  = 1'b0;
        s_data   = '0;
        mid_drop = 1'b0;
        exp_uf   = '0;
        mode     = M_IDLE;
        for (int k = 0; k < NCH; k++) last_w[k] = '0;
        set_all(12'h000);

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset.underflow_cnt", underflow_cnt, 0);

        // Release with enable high: preamble then RUN
        rstb = 1'b1;
        start_sync();
        @(negedge clk);
        preamble(2'($urandom_range(0, 3)));

        // First RUN frame: hand over lane0=A5C, lane7=3E1
        nxt_en    = 1'b1;
        nxt_sel   = 2'b00;
        nxt_valid = 1'b1;
        nxt_data  = {$urandom(), $urandom(), $urandom()};
        nxt_data[0*BITS +: BITS] = 12'hA5C;
        nxt_data[7*BITS +: BITS] = 12'h3E1;
        run_frame(BITS);

        // Frame carrying A5C; hand over 123 on all lanes
        nxt_valid = 1'b1;
        nxt_data  = {NCH{12'h123}};
        run_frame(BITS);

        // Three starved frames: 123 is repeated
        nxt_valid = 1'b0;
        for (int f = 0; f < 3; f++) run_frame(BITS);
        check("underflow_after_3", underflow_cnt, 16'd3);

        // Random traffic
        for (int f = 0; f < 40; f++) begin
            rand_inputs();
            run_frame(BITS);
        end

        // enable glitch inside one frame is ignored
        rand_inputs();
        mid_drop = 1'b1;
        run_frame(BITS);

        // enable drops at bit 5: frame completes, then IDLE
        rand_inputs();
        nxt_en = 1'b0;
        run_frame(BITS);
        mid_drop = 1'b0;
        check_idle(6);

        // Re-enable: fresh preamble, then ramp selection from RUN entry
        start_sync();
        @(negedge clk);
        preamble(2'b01);
        for (int f = 0; f < RAMP_FRAMES; f++) begin
            rand_inputs();
            nxt_sel = 2'b01;
            run_frame(BITS);
        end
        for (int f = 0; f < 10; f++) begin
            rand_inputs();
            run_frame(BITS);
        end

        // Asynchronous reset in the middle of a frame
        rand_inputs();
        run_frame(5);
        rstb = 1'b0;
        #1;
        check_quiet("async_reset");
        check("async_reset.underflow_cnt", underflow_cnt, 0);
        exp_uf = '0;
        mode   = M_IDLE;
        for (int k = 0; k < NCH; k++) last_w[k] = '0;
        set_all(12'h000);
        @(negedge clk);
        check_quiet("in_reset");

        // Restart: last word must be back to 0 on the first RUN frame
        rstb = 1'b1;
        start_sync();
        @(negedge clk);
        preamble(2'b00);
        for (int f = 0; f < 8; f++) begin
            rand_inputs();
            run_frame(BITS);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
